// File: rtl/ins_mem_loader_pkg.sv
// Shared definitions for the instruction memory boot loader.
package ins_mem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_WRITE,
    S_RELEASE,
    S_START,
    S_DONE
  } state_t;

  localparam int unsigned ERR_NIBBLE   = 0;
  localparam int unsigned ERR_OVERFLOW = 1;

  function automatic logic cpu_released(input state_t s);
    return s inside {S_RELEASE, S_START, S_DONE};
  endfunction

endpackage

// File: rtl/ins_mem_loader.sv
// Boot loader: packs byte pairs into instruction words, writes them from address 0,
// then releases the processor reset and pulses start.
module ins_mem_loader
  import ins_mem_loader_pkg::*;
#(
  parameter int unsigned reg_width  = 12,
  parameter int unsigned Im_width   = 8,
  parameter int unsigned WORD_COUNT = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_req,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [Im_width-1:0] im_address,
  output logic [reg_width-1:0] im_data,
  output logic                im_wren,
  output logic                cpu_reset,
  output logic                start,
  output logic                busy,
  output logic                done,
  output logic [Im_width:0]   loaded_count,
  output logic [1:0]          err
);

  localparam logic [Im_width-1:0] LAST_ADDR  = Im_width'(WORD_COUNT - 1);
  localparam logic [Im_width:0]   FULL_COUNT = (Im_width + 1)'(WORD_COUNT);
  localparam logic [Im_width-1:0] ADDR_ONE   = {{(Im_width - 1){1'b0}}, 1'b1};

  state_t              state, state_next;
  logic [Im_width-1:0] counter;
  logic [7:0]          word_lo;
  logic                last_q;
  logic                xfer;

  assign in_ready = (state == S_LOW) || (state == S_HIGH);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE: if (load_req) state_next = S_LOW;
      S_LOW:          if (xfer) state_next = S_HIGH;
      S_HIGH:         if (xfer) state_next = S_WRITE;
      S_WRITE:        state_next = (last_q || counter == LAST_ADDR) ? S_RELEASE : S_LOW;
      S_RELEASE:      state_next = S_START;
      S_START:        state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter      <= '0;
      word_lo      <= '0;
      last_q       <= 1'b0;
      err          <= '0;
      loaded_count <= '0;
      im_address   <= '0;
      im_data      <= '0;
      im_wren      <= 1'b0;
      cpu_reset    <= 1'b1;
      start        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      im_wren   <= (state_next == S_WRITE);
      start     <= (state_next == S_START);
      done      <= (state_next == S_DONE);
      busy      <= !(state_next inside {S_IDLE, S_DONE});
      cpu_reset <= !cpu_released(state_next);

      unique case (state)
        S_IDLE, S_DONE: begin
          if (load_req) begin
            counter      <= '0;
            err          <= '0;
            loaded_count <= '0;
          end
        end
        S_LOW: begin
          if (xfer) word_lo <= in_data;
        end
        S_HIGH: begin
          // Word is assembled straight into the write register; only the low nibble is kept.
          if (xfer) begin
            last_q     <= in_last;
            im_address <= counter;
            im_data    <= {in_data[reg_width-9:0], word_lo};
            if (in_data[7:reg_width-8] != '0) err[ERR_NIBBLE] <= 1'b1;
          end
        end
        S_WRITE: begin
          if (last_q) begin
            loaded_count <= {1'b0, counter} + {{Im_width{1'b0}}, 1'b1};
          end else if (counter == LAST_ADDR) begin
            err[ERR_OVERFLOW] <= 1'b1;
            loaded_count      <= FULL_COUNT;
          end else begin
            counter <= counter + ADDR_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed, table-driven bench for ins_mem_loader (instantiated with a 4-word memory).
module tb_ins_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_req;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  im_address;
  logic [11:0] im_data;
  logic        im_wren;
  logic        cpu_reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [8:0]  loaded_count;
  logic [1:0]  err;

  ins_mem_loader #(.reg_width(12), .Im_width(8), .WORD_COUNT(4)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .im_address(im_address), .im_data(im_data), .im_wren(im_wren),
    .cpu_reset(cpu_reset), .start(start), .busy(busy), .done(done),
    .loaded_count(loaded_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic        last;
    logic [11:0] exp;
  } word_t;

  typedef struct {
    int unsigned first;
    int unsigned nwords;
    bit          toggle;
    int unsigned nwrites;
    logic [1:0]  exp_err;
    logic [8:0]  exp_lc;
  } load_t;

  word_t words[9];
  load_t loads[5];

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int acc_cnt = 0;
  int hi_cyc = -100;
  int last_wren_cyc = -100;
  int start_cyc = -100;
  int start_cnt = 0;
  logic [7:0]  wr_addr[$];
  logic [11:0] wr_data[$];
  bit toggle_phase = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Observe outputs mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    cyc++;
    if (im_wren) begin
      wr_addr.push_back(im_address);
      wr_data.push_back(im_data);
      last_wren_cyc = cyc;
      check("hi_to_wren_latency", 32'(cyc - hi_cyc), 32'd1);
    end
    if (start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (in_valid && in_ready) begin
      if (acc_cnt % 2 == 1) hi_cyc = cyc;
      acc_cnt++;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte transferred or the bound expired.
  task automatic send_byte(input logic [7:0] b, input logic l, input bit toggle, output bit ok);
    ok = 1'b0;
    in_data = b;
    in_last = l;
    for (int n = 0; n < 16; n++) begin
      if (toggle) begin
        toggle_phase = ~toggle_phase;
        in_valid = toggle_phase;
      end else begin
        in_valid = 1'b1;
      end
      @(negedge clk);
      if (in_valid && in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_load_req();
    wr_addr.delete();
    wr_data.delete();
    acc_cnt = 0;
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    check("entry_cpu_reset", cpu_reset, 1'b1);
    check("entry_in_ready", in_ready, 1'b1);
    check("entry_busy", busy, 1'b1);
    check("entry_done", done, 1'b0);
    check("entry_err_clear", err, 2'b00);
    check("entry_lc_clear", loaded_count, 9'd0);
  endtask

  task automatic run_load(input load_t ld);
    bit    ok;
    int    starts_before;
    word_t w;
    starts_before = start_cnt;
    pulse_load_req();
    for (int unsigned i = 0; i < ld.nwords; i++) begin
      w = words[ld.first + i];
      // in_last is asserted on every low beat; it must be ignored there.
      send_byte(w.lo, 1'b1, ld.toggle, ok);
      if (i < ld.nwrites) begin
        check("lo_accepted", ok, 1'b1);
      end else begin
        check("lo_refused", ok, 1'b0);
      end
      if (!ok) break;
      send_byte(w.hi, w.last, ld.toggle, ok);
      check("hi_accepted", ok, 1'b1);
      if (!ok) break;
    end
    for (int n = 0; n < 20 && !done; n++) @(negedge clk);
    check("reached_done", done, 1'b1);
    check("write_count", wr_addr.size(), ld.nwrites);
    for (int i = 0; i < wr_addr.size() && i < int'(ld.nwrites); i++) begin
      check("write_addr", wr_addr[i], i);
      check("write_data", wr_data[i], words[ld.first + i].exp);
    end
    check("loaded_count", loaded_count, ld.exp_lc);
    check("err", err, ld.exp_err);
    check("start_pulses", start_cnt - starts_before, 1);
    check("wren_to_start", 32'(start_cyc - last_wren_cyc), 32'd2);
    check("done_cpu_reset", cpu_reset, 1'b0);
    check("done_in_ready", in_ready, 1'b0);
    check("done_busy", busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    int starts_before;

    words[0] = '{8'h34, 8'h01, 1'b0, 12'h134};
    words[1] = '{8'hAB, 8'h0F, 1'b1, 12'hFAB};
    words[2] = '{8'h22, 8'hF5, 1'b1, 12'h522};
    words[3] = '{8'h11, 8'h02, 1'b0, 12'h211};
    words[4] = '{8'h33, 8'h04, 1'b0, 12'h433};
    words[5] = '{8'h55, 8'h06, 1'b0, 12'h655};
    words[6] = '{8'h77, 8'h08, 1'b0, 12'h877};
    words[7] = '{8'h99, 8'h0A, 1'b0, 12'hA99};
    words[8] = '{8'hC3, 8'h0E, 1'b1, 12'hEC3};

    loads[0] = '{0, 2, 1'b0, 2, 2'b00, 9'd2};
    loads[1] = '{0, 2, 1'b1, 2, 2'b00, 9'd2};
    loads[2] = '{2, 1, 1'b0, 1, 2'b01, 9'd1};
    loads[3] = '{3, 5, 1'b0, 4, 2'b10, 9'd4};
    loads[4] = '{8, 1, 1'b0, 1, 2'b00, 9'd1};

    reset = 1'b1;
    load_req = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_im_wren", im_wren, 1'b0);
    check("rst_start", start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_loaded_count", loaded_count, 9'd0);
    check("rst_err", err, 2'b00);
    check("rst_im_address", im_address, 8'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_cpu_reset", cpu_reset, 1'b1);
    check("idle_in_ready", in_ready, 1'b0);

    for (int k = 0; k < 4; k++) run_load(loads[k]);

    // Asynchronous reset while the second word's high byte is awaited.
    starts_before = start_cnt;
    pulse_load_req();
    send_byte(words[0].lo, 1'b0, 1'b0, ok);
    send_byte(words[0].hi, 1'b0, 1'b0, ok);
    send_byte(words[1].lo, 1'b0, 1'b0, ok);
    check("pre_reset_in_ready", in_ready, 1'b1);
    reset = 1'b1;
    #2;
    check("async_cpu_reset", cpu_reset, 1'b1);
    check("async_in_ready", in_ready, 1'b0);
    check("async_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("aborted_no_start", start_cnt - starts_before, 0);
    check("aborted_writes", wr_addr.size(), 1);
    check("aborted_stays_idle", cpu_reset, 1'b1);

    run_load(loads[0]);
    run_load(loads[4]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
